// File: rtl/pig_pkg.sv
// Shared definitions for the board input conditioning blocks:
// key FSM state encoding and default 50 MHz timing constants.
package pig_pkg;

    typedef enum logic [2:0] {
        KS_IDLE       = 3'd0,
        KS_PRESS_DB   = 3'd1,
        KS_HELD       = 3'd2,
        KS_REPEAT     = 3'd3,
        KS_RELEASE_DB = 3'd4
    } ks_state_e;

    localparam int unsigned KS_CLK_HZ            = 50_000_000;
    localparam int unsigned KS_DEBOUNCE_CYC      = 1_000_000;
    localparam int unsigned KS_REPEAT_DELAY_CYC  = 25_000_000;
    localparam int unsigned KS_REPEAT_PERIOD_CYC = 5_000_000;

    function automatic int unsigned ks_max3(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/key_sync.sv
// Two-flop synchroniser for an asynchronous board input; the reset value
// is a parameter so the idle level of the pin can be preloaded.
module key_sync #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/key_step_gen.sv
// Push-button conditioner: synchronise, debounce, and turn presses (and
// optional auto-repeat while held) into single-cycle step pulses.
module key_step_gen
    import pig_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC      = KS_DEBOUNCE_CYC,
    parameter int unsigned REPEAT_DELAY_CYC  = KS_REPEAT_DELAY_CYC,
    parameter int unsigned REPEAT_PERIOD_CYC = KS_REPEAT_PERIOD_CYC,
    parameter logic        REPEAT_EN         = 1'b1,
    parameter logic        KEY_ACTIVE_LOW    = 1'b1
) (
    input  logic clk_50,
    input  logic rst_key0,
    input  logic key_raw,
    output logic key_clean,
    output logic step_pulse,
    output logic repeat_active
);

    localparam int unsigned CNT_MAX = ks_max3(DEBOUNCE_CYC, REPEAT_DELAY_CYC, REPEAT_PERIOD_CYC);
    localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY_CYC - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = '1;

    logic             key_sync_s;
    logic             key_s;
    ks_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clean_q, clean_d;
    logic             pulse_q, pulse_d;
    logic             repeat_q, repeat_d;

    // Synchroniser idles at the pin's "not pressed" level.
    key_sync #(
        .RESET_VAL(KEY_ACTIVE_LOW)
    ) u_key_sync (
        .clk_i(clk_50),
        .rst_i(rst_key0),
        .d_i  (key_raw),
        .q_o  (key_sync_s)
    );

    assign key_s = key_sync_s ^ KEY_ACTIVE_LOW;

    always_ff @(posedge clk_50 or posedge rst_key0) begin
        if (rst_key0) begin
            state_q  <= KS_IDLE;
            cnt_q    <= '0;
            clean_q  <= 1'b0;
            pulse_q  <= 1'b0;
            repeat_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            clean_q  <= clean_d;
            pulse_q  <= pulse_d;
            repeat_q <= repeat_d;
        end
    end

    // A key_s change is tested before any terminal count so it always wins.
    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
        clean_d = clean_q;
        pulse_d = 1'b0;

        case (state_q)
            KS_IDLE: begin
                if (key_s) state_d = KS_PRESS_DB;
            end
            KS_PRESS_DB: begin
                if (!key_s) begin
                    state_d = KS_IDLE;
                end else if (cnt_q == DB_LAST) begin
                    state_d = KS_HELD;
                    clean_d = 1'b1;
                    pulse_d = 1'b1;
                end
            end
            KS_HELD: begin
                if (!key_s) begin
                    state_d = KS_RELEASE_DB;
                end else if (REPEAT_EN && (cnt_q == DLY_LAST)) begin
                    state_d = KS_REPEAT;
                    pulse_d = 1'b1;
                end
            end
            KS_REPEAT: begin
                if (!key_s) begin
                    state_d = KS_RELEASE_DB;
                end else if (cnt_q == PER_LAST) begin
                    pulse_d = 1'b1;
                    cnt_d   = '0;
                end
            end
            KS_RELEASE_DB: begin
                if (key_s) begin
                    state_d = KS_HELD;
                end else if (cnt_q == DB_LAST) begin
                    state_d = KS_IDLE;
                    clean_d = 1'b0;
                end
            end
            default: state_d = KS_IDLE;
        endcase

        if (state_d != state_q) cnt_d = '0;

        repeat_d = (state_d == KS_REPEAT);
    end

    assign key_clean     = clean_q;
    assign step_pulse    = pulse_q;
    assign repeat_active = repeat_q;

endmodule

// File: tb/tb_key_step_gen.sv
// Directed bench for key_step_gen with short timing (debounce 4, delay 10,
// period 3); a second instance runs with auto-repeat disabled.
module tb_key_step_gen;
    import pig_pkg::*;

    logic clk_50   = 1'b0;
    logic rst_key0 = 1'b1;
    logic key_raw  = 1'b1;

    logic key_clean, step_pulse, repeat_active;
    logic nr_clean, nr_pulse, nr_repeat;

    int unsigned n_assert  = 0;
    int unsigned n_fail    = 0;
    int unsigned pulse_cnt = 0;
    int unsigned base_cnt  = 0;
    int unsigned cyc       = 0;
    logic        prev_pulse = 1'b0;

    always #5 clk_50 = ~clk_50;

    key_step_gen #(
        .DEBOUNCE_CYC     (4),
        .REPEAT_DELAY_CYC (10),
        .REPEAT_PERIOD_CYC(3),
        .REPEAT_EN        (1'b1),
        .KEY_ACTIVE_LOW   (1'b1)
    ) dut (
        .clk_50       (clk_50),
        .rst_key0     (rst_key0),
        .key_raw      (key_raw),
        .key_clean    (key_clean),
        .step_pulse   (step_pulse),
        .repeat_active(repeat_active)
    );

    key_step_gen #(
        .DEBOUNCE_CYC     (4),
        .REPEAT_DELAY_CYC (10),
        .REPEAT_PERIOD_CYC(3),
        .REPEAT_EN        (1'b0),
        .KEY_ACTIVE_LOW   (1'b1)
    ) dut_nr (
        .clk_50       (clk_50),
        .rst_key0     (rst_key0),
        .key_raw      (key_raw),
        .key_clean    (nr_clean),
        .step_pulse   (nr_pulse),
        .repeat_active(nr_repeat)
    );

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s@%0d observed=%0d expected=%0d", tag, k, obs, exp);
        end
    endtask

    // One clock: sample 1 time unit after the edge, track pulse width and count.
    task automatic tick();
        @(posedge clk_50);
        #1;
        chk("pulse_width", int'(cyc), {31'b0, step_pulse & prev_pulse}, 32'd0);
        if (step_pulse === 1'b1) pulse_cnt++;
        prev_pulse = step_pulse;
        cyc++;
    endtask

    task automatic chk_outs(input string sc, input int k,
                            input logic p, input logic c, input logic r,
                            input logic np, input logic nc, input logic nrr);
        chk({sc, ".pulse"},    k, {31'b0, step_pulse},    {31'b0, p});
        chk({sc, ".clean"},    k, {31'b0, key_clean},     {31'b0, c});
        chk({sc, ".repeat"},   k, {31'b0, repeat_active}, {31'b0, r});
        chk({sc, ".nr_pulse"}, k, {31'b0, nr_pulse},      {31'b0, np});
        chk({sc, ".nr_clean"}, k, {31'b0, nr_clean},      {31'b0, nc});
        chk({sc, ".nr_rep"},   k, {31'b0, nr_repeat},     {31'b0, nrr});
    endtask

    task automatic idle(input int n);
        key_raw = 1'b1;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        // 1: reset held while the key toggles, then release with key idle
        for (int k = 0; k < 8; k++) begin
            tick();
            chk_outs("s1_rst", k, 0, 0, 0, 0, 0, 0);
            key_raw = ~key_raw;
        end
        key_raw = 1'b1;
        tick();
        rst_key0 = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk_outs("s1_run", k, 0, 0, 0, 0, 0, 0);
        end

        // 2: clean press, 8 cycles, release
        base_cnt = pulse_cnt;
        key_raw = 1'b0;
        for (int k = 0; k < 17; k++) begin
            tick();
            chk_outs("s2", k, k == 6, (k >= 6) && (k < 14), 0,
                     k == 6, (k >= 6) && (k < 14), 0);
            if (k == 7) key_raw = 1'b1;
        end
        chk("s2.count", 0, pulse_cnt - base_cnt, 32'd1);
        idle(4);

        // 3: two-cycle bounce rejected
        base_cnt = pulse_cnt;
        key_raw = 1'b0;
        for (int k = 0; k < 11; k++) begin
            tick();
            chk_outs("s3", k, 0, 0, 0, 0, 0, 0);
            if (k == 1) key_raw = 1'b1;
        end
        chk("s3.count", 0, pulse_cnt - base_cnt, 32'd0);
        chk("s3.state", 0, 32'(dut.state_q), 32'(KS_IDLE));
        idle(4);

        // 4: long hold with auto-repeat; release sampled at offset 30
        base_cnt = pulse_cnt;
        key_raw = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            chk_outs("s4", k,
                     (k == 6) || (k == 16) || (k == 19) || (k == 22) ||
                     (k == 25) || (k == 28) || (k == 31),
                     (k >= 6) && (k < 36), (k >= 16) && (k < 32),
                     k == 6, (k >= 6) && (k < 36), 0);
            if (k == 29) key_raw = 1'b1;
        end
        chk("s4.count", 0, pulse_cnt - base_cnt, 32'd7);
        idle(4);

        // 5: two-cycle release glitch while held restarts the repeat delay
        base_cnt = pulse_cnt;
        key_raw = 1'b0;
        for (int k = 0; k < 36; k++) begin
            tick();
            chk_outs("s5", k,
                     (k == 6) || (k == 22) || (k == 25) || (k == 28),
                     (k >= 6) && (k < 33), (k >= 22) && (k < 29),
                     k == 6, (k >= 6) && (k < 33), 0);
            if (k == 7)  key_raw = 1'b1;
            if (k == 9)  key_raw = 1'b0;
            if (k == 26) key_raw = 1'b1;
        end
        chk("s5.count", 0, pulse_cnt - base_cnt, 32'd4);
        idle(4);

        // 6: async reset during auto-repeat, key kept pressed
        base_cnt = pulse_cnt;
        key_raw = 1'b0;
        for (int k = 0; k < 19; k++) begin
            tick();
            chk_outs("s6_pre", k, (k == 6) || (k == 16), k >= 6, k >= 16,
                     k == 6, k >= 6, 0);
        end
        #2;
        rst_key0 = 1'b1;
        #1;
        chk_outs("s6_async", 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_outs("s6_hold", k, 0, 0, 0, 0, 0, 0);
        end
        rst_key0 = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            chk_outs("s6_post", k, k == 6, k >= 6, 0, k == 6, k >= 6, 0);
        end
        chk("s6.count", 0, pulse_cnt - base_cnt, 32'd3);
        idle(12);
        chk("end.clean", 0, {31'b0, key_clean}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
